// File: rtl/core_pkg.sv
// Shared types and default sizing for the psum drain datapath.
// Pure declarations: no logic, no timing.
package core_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } drain_state_t;

    localparam int COL     = 8;
    localparam int PSUM_BW = 16;

endpackage

// File: rtl/psum_lane_alu.sv
// One psum lane: optional wrap-around accumulate, optional ReLU (PSUM_DRAIN_RELU_EN).
// Purely combinational, no handshake.
module psum_lane_alu #(
    parameter int psum_bw = 16
) (
    input  logic               acc_en,
    input  logic [psum_bw-1:0] cap,
    input  logic [psum_bw-1:0] mem_q,
    output logic [psum_bw-1:0] y
);

    logic [psum_bw-1:0] sum;

    // Plain modulo-2^psum_bw add; overflow wraps by truncation.
    assign sum = acc_en ? (cap + mem_q) : cap;

`ifdef PSUM_DRAIN_RELU_EN
    assign y = sum[psum_bw-1] ? '0 : sum;
`else
    assign y = sum;
`endif

endmodule

// File: rtl/psum_drain.sv
// Drains OFIFO psum vectors into PMEM, optionally read-modify-write accumulating; ReLU via PSUM_DRAIN_RELU_EN.
// Two cycles per vector (FETCH, WRITE); stalls in FETCH while the OFIFO head is not valid.
module psum_drain
    import core_pkg::*;
#(
    parameter int col     = COL,
    parameter int psum_bw = PSUM_BW,
    parameter int addr_bw = 11
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [addr_bw-1:0]     num_rows,
    input  logic [addr_bw-1:0]     base_addr,
    input  logic                   acc_mode,
    input  logic                   ofifo_valid,
    input  logic [col*psum_bw-1:0] ofifo_out,
    output logic                   ofifo_rd,
    output logic                   pmem_cen,
    output logic                   pmem_wen,
    output logic [addr_bw-1:0]     pmem_addr,
    output logic [col*psum_bw-1:0] pmem_d,
    input  logic [col*psum_bw-1:0] pmem_q,
    output logic                   busy,
    output logic                   done
);

    drain_state_t           state_q;
    logic [addr_bw-1:0]     rows_q;
    logic [addr_bw-1:0]     addr_q;
    logic [addr_bw-1:0]     cnt_q;
    logic                   acc_q;
    logic [col*psum_bw-1:0] data_q;
    logic [col*psum_bw-1:0] alu_y;

    logic in_fetch;
    logic in_write;
    logic pop;
    logic rd_issue;

    assign in_fetch = (state_q == FETCH);
    assign in_write = (state_q == WRITE);
    assign pop      = in_fetch && ofifo_valid;
    assign rd_issue = pop && acc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rows_q  <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (num_rows != '0) begin
                            state_q <= FETCH;
                            rows_q  <= num_rows;
                            addr_q  <= base_addr;
                            acc_q   <= acc_mode;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= DONE;
                        end
                    end
                end
                FETCH: begin
                    if (ofifo_valid) begin
                        data_q  <= ofifo_out;
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    if (cnt_q == rows_q - addr_bw'(1)) begin
                        state_q <= DONE;
                    end else begin
                        cnt_q   <= cnt_q + addr_bw'(1);
                        addr_q  <= addr_q + addr_bw'(1);
                        state_q <= FETCH;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // PMEM strobes decode straight from state so reset idles them immediately.
    assign ofifo_rd  = pop;
    assign pmem_cen  = !(in_write || rd_issue);
    assign pmem_wen  = !in_write;
    assign pmem_addr = (in_write || rd_issue) ? addr_q : '0;
    assign pmem_d    = in_write ? alu_y : '0;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

    for (genvar i = 0; i < col; i++) begin : g_lane
        psum_lane_alu #(
            .psum_bw(psum_bw)
        ) u_lane (
            .acc_en(acc_q),
            .cap   (data_q[psum_bw*i +: psum_bw]),
            .mem_q (pmem_q[psum_bw*i +: psum_bw]),
            .y     (alu_y[psum_bw*i +: psum_bw])
        );
    end

endmodule

// File: tb/tb_psum_drain.sv
// Directed bench for psum_drain: streaming, accumulate/wrap, zero rows, address wrap, stall, reset abort.
module tb_psum_drain;

    localparam int AW = 11;
    localparam int VW = 128;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] num_rows = '0;
    logic [AW-1:0] base_addr = '0;
    logic          acc_mode = 1'b0;
    logic          ofifo_valid = 1'b0;
    logic [VW-1:0] ofifo_out = '0;
    logic          ofifo_rd;
    logic          pmem_cen;
    logic          pmem_wen;
    logic [AW-1:0] pmem_addr;
    logic [VW-1:0] pmem_d;
    logic [VW-1:0] pmem_q = '0;
    logic          busy;
    logic          done;

    psum_drain #(.col(8), .psum_bw(16), .addr_bw(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_rows   (num_rows),
        .base_addr  (base_addr),
        .acc_mode   (acc_mode),
        .ofifo_valid(ofifo_valid),
        .ofifo_out  (ofifo_out),
        .ofifo_rd   (ofifo_rd),
        .pmem_cen   (pmem_cen),
        .pmem_wen   (pmem_wen),
        .pmem_addr  (pmem_addr),
        .pmem_d     (pmem_d),
        .pmem_q     (pmem_q),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Synchronous single-port PMEM model.
    logic [VW-1:0] mem [2048];
    always @(posedge clk) begin
        if (!pmem_cen) begin
            if (pmem_wen) pmem_q <= mem[pmem_addr];
            else          mem[pmem_addr] <= pmem_d;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [VW-1:0] mk(input logic [15:0] l7, l6, l5, l4, l3, l2, l1, l0);
        return {l7, l6, l5, l4, l3, l2, l1, l0};
    endfunction

    logic [VW-1:0] vec [4];
    logic [VW-1:0] va [4];
    logic [VW-1:0] vb [4];
    logic [AW-1:0] wa [16];
    logic [VW-1:0] wd [16];
    logic [AW-1:0] ra [16];
    int wc [16];
    int pc [16];
    int rc [16];
    int nwr, npop, nrd, ndone, done_cyc, viol;

    // Cycle 0 presents start; one loop iteration per clock, sampled 1 ns after the edge.
    task automatic drain(input int n, input logic [AW-1:0] base, input logic acc,
                         input int stall_from, input int stall_len,
                         input int restart_cyc, input int abort_cyc);
        nwr = 0; npop = 0; nrd = 0; ndone = 0; done_cyc = -1; viol = 0;
        for (int c = 0; c < 60; c++) begin
            start       = (c == 0) || (c == restart_cyc);
            num_rows    = (c == 0) ? AW'(n) : AW'(1);
            base_addr   = (c == 0) ? base : AW'(11'h055);
            acc_mode    = (c == 0) ? acc : !acc;
            ofifo_valid = !(c >= stall_from && c < stall_from + stall_len);
            ofifo_out   = vec[npop % 4];
            #1;
            if (c == abort_cyc) begin
                reset = 1'b0;
                #1;
                check("abort_rd",   ofifo_rd,  1'b0);
                check("abort_cen",  pmem_cen,  1'b1);
                check("abort_wen",  pmem_wen,  1'b1);
                check("abort_addr", pmem_addr, '0);
                check("abort_d",    pmem_d,    '0);
                check("abort_busy", busy,      1'b0);
                check("abort_done", done,      1'b0);
                start = 1'b0;
                ofifo_valid = 1'b0;
                @(posedge clk); #1;
                reset = 1'b1;
                return;
            end
            if (ofifo_rd) begin
                if (npop < 16) pc[npop] = c;
                npop++;
                if (!ofifo_valid || !busy) viol++;
            end
            if (!pmem_cen && !pmem_wen) begin
                if (nwr < 16) begin wa[nwr] = pmem_addr; wd[nwr] = pmem_d; wc[nwr] = c; end
                nwr++;
            end
            if (!pmem_cen && pmem_wen) begin
                if (nrd < 16) begin ra[nrd] = pmem_addr; rc[nrd] = c; end
                nrd++;
            end
            if (c >= stall_from && c < stall_from + stall_len && (!pmem_cen || ofifo_rd || !busy))
                viol++;
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = c;
            end
            @(posedge clk); #1;
            if (done_cyc >= 0 && c >= done_cyc + 2) break;
        end
        start = 1'b0;
        ofifo_valid = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 8; i++) begin
                va[k][16*i +: 16] = 16'(k * 256 + i + 1);
                vb[k][16*i +: 16] = 16'(16'h1000 + k * 16 + i);
            end
        end

        // Reset state
        #1;
        check("rst_rd",   ofifo_rd,  1'b0);
        check("rst_cen",  pmem_cen,  1'b1);
        check("rst_wen",  pmem_wen,  1'b1);
        check("rst_addr", pmem_addr, '0);
        check("rst_d",    pmem_d,    '0);
        check("rst_busy", busy,      1'b0);
        check("rst_done", done,      1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Four rows streamed at full rate; a start mid-drain must be ignored
        for (int k = 0; k < 4; k++) vec[k] = va[k];
        drain(4, 11'h010, 1'b0, 100, 0, 3, -1);
        check("str_nwr", nwr, 4);
        for (int i = 0; i < 4; i++) begin
            check("str_addr", wa[i], AW'(16 + i));
            check("str_cyc",  wc[i], 2 + 2 * i);
            check("str_data", wd[i], va[i]);
        end
        check("str_npop", npop, 4);
        check("str_pop0", pc[0], 1);
        check("str_nrd",  nrd, 0);
        check("str_done", done_cyc, 9);
        check("str_ndone", ndone, 1);
        check("str_viol", viol, 0);

        // Preload 0x20, then accumulate into it
        vec[0] = mk(16'h7FFF, 16'h0000, 16'h0002, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h0005);
        drain(1, 11'h020, 1'b0, 100, 0, -1, -1);
        check("pre_data", wd[0], vec[0]);
        check("pre_done", done_cyc, 3);

        vec[0] = mk(16'h0001, 16'h0000, 16'hFFF0, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0003);
        drain(1, 11'h020, 1'b1, 100, 0, -1, -1);
        check("acc_nrd",   nrd, 1);
        check("acc_raddr", ra[0], 11'h020);
        check("acc_rcyc",  rc[0], 1);
        check("acc_pop",   pc[0], 1);
        check("acc_waddr", wa[0], 11'h020);
        check("acc_wcyc",  wc[0], 2);
        check("acc_lane0", wd[0][15:0], 16'h0008);
`ifdef PSUM_DRAIN_RELU_EN
        check("acc_data", wd[0], mk(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h00FF, 16'h0000, 16'h0000, 16'h0008));
`else
        check("acc_data", wd[0], mk(16'h8000, 16'h0000, 16'hFFF2, 16'h0000, 16'h00FF, 16'h0000, 16'h0000, 16'h0008));
`endif

        // Zero rows completes immediately without touching OFIFO or PMEM
        drain(0, 11'h030, 1'b0, 100, 0, -1, -1);
        check("zero_done", done_cyc, 1);
        check("zero_npop", npop, 0);
        check("zero_nwr",  nwr, 0);
        check("zero_nrd",  nrd, 0);

        // Address wraps past the top of PMEM
        for (int k = 0; k < 4; k++) vec[k] = va[k];
        drain(2, 11'h7FF, 1'b0, 100, 0, -1, -1);
        check("wrap_addr0", wa[0], 11'h7FF);
        check("wrap_addr1", wa[1], 11'h000);
        check("wrap_done",  done_cyc, 5);

        // OFIFO empty for five cycles after the first row
        drain(3, 11'h040, 1'b0, 3, 5, -1, -1);
        check("stall_pop1", pc[1], 8);
        check("stall_wc1",  wc[1], 9);
        check("stall_wc2",  wc[2], 11);
        check("stall_d1",   wd[1], va[1]);
        check("stall_addr2", wa[2], 11'h042);
        check("stall_done", done_cyc, 12);
        check("stall_viol", viol, 0);

        // Reset during the second row's write, then a clean restart
        for (int k = 0; k < 4; k++) vec[k] = vb[k];
        drain(4, 11'h010, 1'b0, 100, 0, -1, 4);
        check("abort_nwr",   nwr, 1);
        check("abort_ndone", ndone, 0);
        check("abort_mem0",  mem[11'h010], vb[0]);
        check("abort_mem1",  mem[11'h011], va[1]);
        drain(4, 11'h010, 1'b0, 100, 0, -1, -1);
        check("again_addr0", wa[0], 11'h010);
        check("again_wc0",   wc[0], 2);
        check("again_d3",    wd[3], vb[3]);
        check("again_done",  done_cyc, 9);
        check("again_mem1",  mem[11'h011], vb[1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
